// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file types and writeback arbiter constants
package regfile_wb_arbiter_pkg;
  localparam int NUM_WB_SRC  = 4;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_WIDTH_W = 32;
  typedef logic                   bool_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
  typedef logic [REG_WIDTH_W-1:0] reg_width_t;
  typedef struct packed {
    bool_t      valid;
    reg_addr_t  addr;
    reg_width_t data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// rr_pick2: rotating find-first picker producing two grants from a priority pointer
//   req0_i        candidates for the first grant
//   req1_i        candidates for the second grant (must exclude the first winner)
//   ptr_i         highest-priority index
//   gnt*_o/v*_o   one-hot grants and their valid bits; idx*_o the granted indices
module rr_pick2 #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req0_i,
  input  logic [N-1:0]  req1_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt0_o,
  output logic [N-1:0]  gnt1_o,
  output logic          v0_o,
  output logic          v1_o,
  output logic [PW-1:0] idx0_o,
  output logic [PW-1:0] idx1_o
);
  logic [PW-1:0] s0, s1;
  // Scan from lowest to highest priority so the last hit is the highest-priority one.
  always_comb begin
    v0_o = 1'b0;
    idx0_o = '0;
    s0 = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s0 = PW'((int'(ptr_i) + k) % N);
      if (req0_i[s0]) begin
        v0_o = 1'b1;
        idx0_o = s0;
      end
    end
  end
  // req1_i is a subset of req0_i without the first winner, so its first hit follows the first winner.
  always_comb begin
    v1_o = 1'b0;
    idx1_o = '0;
    s1 = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s1 = PW'((int'(ptr_i) + k) % N);
      if (req1_i[s1]) begin
        v1_o = 1'b1;
        idx1_o = s1;
      end
    end
  end
  assign gnt0_o = v0_o ? N'(1) << idx0_o : '0;
  assign gnt1_o = v1_o ? N'(1) << idx1_o : '0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the two regfile write ports among NUM_SRC writeback sources
//   src_valid/src_addr/src_data  per-source write requests, held until src_ready
//   src_ready                    request accepted this cycle (combinational)
//   wr_ena/wr_addr/wr_data       registered regfile write ports 0 and 1
//   rr_ptr_o                     current highest-priority source
module regfile_wb_arbiter import regfile_wb_arbiter_pkg::*; #(
  parameter int NUM_SRC = NUM_WB_SRC,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_WIDTH_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [1:0]                      wr_ena,
  output logic [1:0][ADDR_W-1:0]          wr_addr,
  output logic [1:0][DATA_W-1:0]          wr_data,
  output logic [$clog2(NUM_SRC)-1:0]      rr_ptr_o
);
  localparam int PW = $clog2(NUM_SRC);
  logic [NUM_SRC-1:0] elig, elig1, gnt0, gnt1;
  logic v0, v1;
  logic [PW-1:0] idx0, idx1, last, ptr_q, ptr_d;
  logic [1:0] ena_q, ena_d;
  logic [1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [1:0][DATA_W-1:0] data_q, data_d;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) elig[i] = src_valid[i] && (src_addr[i] != '0);
  end
  // Second port may not target the register already granted to port 0.
  always_comb begin
    elig1 = '0;
    for (int i = 0; i < NUM_SRC; i++) elig1[i] = elig[i] && (src_addr[i] != src_addr[idx0]);
  end
  rr_pick2 #(.N(NUM_SRC), .PW(PW)) u_pick (
    .req0_i(elig), .req1_i(elig1), .ptr_i(ptr_q),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .v0_o(v0), .v1_o(v1), .idx0_o(idx0), .idx1_o(idx1)
  );
  // Writes to r0 are discarded, so they are accepted at once without a port.
  assign src_ready = rst ? '0 : (src_valid & ~elig) | gnt0 | gnt1;
  always_comb begin
    last = v1 ? idx1 : idx0;
    ptr_d = !v0 ? ptr_q : (last == PW'(NUM_SRC - 1)) ? '0 : last + 1'b1;
    ena_d = {v1, v0};
    addr_d[0] = v0 ? src_addr[idx0] : addr_q[0];
    addr_d[1] = v1 ? src_addr[idx1] : addr_q[1];
    data_d[0] = v0 ? src_data[idx0] : data_q[0];
    data_d[1] = v1 ? src_data[idx1] : data_q[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
    end else begin
      ena_q  <= ena_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
    end
  end
  // A write already registered when reset rises must not reach the regfile.
  assign wr_ena   = rst ? 2'b00 : ena_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign rr_ptr_o = ptr_q;
  always_ff @(posedge clk) begin
    if (!rst) assert (!(ena_q[0] && ena_q[1] && addr_q[0] == addr_q[1]));
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter against a queue-free scan model
module tb_regfile_wb_arbiter;
  localparam int N = 4, AW = 5, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] v = '0;
  logic [N-1:0][AW-1:0] a = '0;
  logic [N-1:0][DW-1:0] d = '0;
  logic [N-1:0] rdy;
  logic [1:0] ena;
  logic [1:0][AW-1:0] wa;
  logic [1:0][DW-1:0] wd;
  logic [1:0] ptr;
  int checks = 0, fails = 0;
  int m_ptr = 0, n_ptr = 0;
  logic [1:0] m_ena = '0, n_ena;
  logic [1:0][AW-1:0] m_addr = '0, n_addr;
  logic [1:0][DW-1:0] m_data = '0, n_data;
  logic [N-1:0] m_rdy, last_rdy;
  logic [DW-1:0] rf_m [2**AW];
  logic [DW-1:0] rf_d [2**AW];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .src_valid(v), .src_addr(a), .src_data(d), .src_ready(rdy),
    .wr_ena(ena), .wr_addr(wa), .wr_data(wd), .rr_ptr_o(ptr)
  );

  // Walk sources in priority order; r0 is accepted for free, up to two distinct registers get ports.
  task automatic model_eval();
    int n, last, i;
    n = 0; last = 0; m_rdy = '0; n_ena = '0;
    n_addr = m_addr; n_data = m_data; n_ptr = m_ptr;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (v[i] && a[i] == 0) m_rdy[i] = 1'b1;
      else if (v[i] && n < 2 && !(n == 1 && n_addr[0] == a[i])) begin
        m_rdy[i] = 1'b1; n_ena[n] = 1'b1; n_addr[n] = a[i]; n_data[n] = d[i];
        last = i; n++;
      end
    end
    if (n > 0) n_ptr = (last + 1) % N;
    if (rst) m_rdy = '0;
  endtask

  // Commit one clock: regfile writes from the visible ports, then advance model state.
  task automatic tick();
    model_eval();
    last_rdy = m_rdy;
    for (int p = 0; p < 2; p++) begin
      if (!rst && m_ena[p]) rf_m[m_addr[p]] = m_data[p];
      if (ena[p] === 1'b1) rf_d[wa[p]] = wd[p];
    end
    if (rst) begin
      m_ena = '0; m_addr = '0; m_data = '0; m_ptr = 0;
    end else begin
      m_ena = n_ena; m_addr = n_addr; m_data = n_data; m_ptr = n_ptr;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    v = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = '1; a = {5'd4, 5'd3, 5'd2, 5'd1}; d = {32'h44, 32'h33, 32'h22, 32'h11};
    #1;
    checks++; if (rdy !== 4'b0000) begin fails++; $display("FAIL reset_ready0 got=%b exp=0000", rdy); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (rdy !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", rdy); end
      checks++; if (ena !== 2'b00) begin fails++; $display("FAIL reset_ena got=%b exp=00", ena); end
      checks++; if (ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
      checks++; if (wa !== '0 || wd !== '0) begin fails++; $display("FAIL reset_wr got=%h/%h exp=0", wa, wd); end
    end
    rst = 1'b0; #1;
    checks++; if (rdy !== 4'b0011) begin fails++; $display("FAIL post_reset_ready got=%b exp=0011", rdy); end
    tick(); v = '0; #1;
    checks++; if (ena !== 2'b11 || wa !== {5'd2, 5'd1}) begin fails++; $display("FAIL post_reset_wr got=%b %h exp=11 0201", ena, wa); end
    checks++; if (ptr !== 2'd2) begin fails++; $display("FAIL post_reset_ptr got=%0d exp=2", ptr); end
  endtask

  task automatic test_two_sources();
    do_reset();
    v = 4'b0101; a = '0; a[0] = 5'd3; a[2] = 5'd7; d[0] = 32'h11; d[2] = 32'h22; #1;
    checks++; if (rdy !== 4'b0101) begin fails++; $display("FAIL two_ready got=%b exp=0101", rdy); end
    tick(); v = '0; #1;
    checks++; if (ena !== 2'b11) begin fails++; $display("FAIL two_ena got=%b exp=11", ena); end
    checks++; if (wa !== {5'd7, 5'd3} || wd !== {32'h22, 32'h11}) begin fails++; $display("FAIL two_wr got=%h %h exp=r3=11 r7=22", wa, wd); end
    checks++; if (ptr !== 2'd3) begin fails++; $display("FAIL two_ptr got=%0d exp=3", ptr); end
  endtask

  task automatic test_four_valid();
    do_reset();
    v = 4'b1111; a = {5'd4, 5'd3, 5'd2, 5'd1}; d = {32'hD4, 32'hD3, 32'hD2, 32'hD1}; #1;
    checks++; if (rdy !== 4'b0011) begin fails++; $display("FAIL four_ready1 got=%b exp=0011", rdy); end
    tick(); v = 4'b1100; #1;
    checks++; if (ena !== 2'b11 || wa !== {5'd2, 5'd1}) begin fails++; $display("FAIL four_wr1 got=%b %h exp=11 r1/r2", ena, wa); end
    checks++; if (ptr !== 2'd2) begin fails++; $display("FAIL four_ptr1 got=%0d exp=2", ptr); end
    checks++; if (rdy !== 4'b1100) begin fails++; $display("FAIL four_ready2 got=%b exp=1100", rdy); end
    tick(); v = '0; #1;
    checks++; if (ena !== 2'b11 || wa !== {5'd4, 5'd3} || wd !== {32'hD4, 32'hD3}) begin fails++; $display("FAIL four_wr2 got=%b %h %h exp=11 r3/r4", ena, wa, wd); end
    checks++; if (ptr !== 2'd0) begin fails++; $display("FAIL four_ptr2 got=%0d exp=0", ptr); end
  endtask

  task automatic test_conflict();
    do_reset();
    v = 4'b1010; a = '0; a[1] = 5'd5; a[3] = 5'd5; d[1] = 32'hAA; d[3] = 32'hBB; #1;
    checks++; if (rdy !== 4'b0010) begin fails++; $display("FAIL conf_ready1 got=%b exp=0010", rdy); end
    tick(); v = 4'b1000; #1;
    checks++; if (ena !== 2'b01 || wa[0] !== 5'd5 || wd[0] !== 32'hAA) begin fails++; $display("FAIL conf_wr1 got=%b %h %h exp=01 r5=aa", ena, wa[0], wd[0]); end
    checks++; if (rdy !== 4'b1000) begin fails++; $display("FAIL conf_ready2 got=%b exp=1000", rdy); end
    tick(); v = '0; #1;
    checks++; if (ena !== 2'b01 || wa[0] !== 5'd5 || wd[0] !== 32'hBB) begin fails++; $display("FAIL conf_wr2 got=%b %h %h exp=01 r5=bb", ena, wa[0], wd[0]); end
    checks++; if (rf_d[5] !== 32'hAA) begin fails++; $display("FAIL conf_rf_mid got=%h exp=aa", rf_d[5]); end
    checks++; if (ptr !== 2'd0) begin fails++; $display("FAIL conf_ptr got=%0d exp=0", ptr); end
    tick();
    checks++; if (rf_d[5] !== 32'hBB) begin fails++; $display("FAIL conf_rf_final got=%h exp=bb", rf_d[5]); end
  endtask

  task automatic test_addr0();
    do_reset();
    v = 4'b0111; a = '0; a[1] = 5'd4; a[2] = 5'd6; d = {32'h0, 32'h66, 32'h44, 32'hFF}; #1;
    checks++; if (rdy !== 4'b0111) begin fails++; $display("FAIL a0_ready got=%b exp=0111", rdy); end
    tick(); v = '0; #1;
    checks++; if (ena !== 2'b11 || wa !== {5'd6, 5'd4}) begin fails++; $display("FAIL a0_wr got=%b %h exp=11 r4/r6", ena, wa); end
    checks++; if (ptr !== 2'd3) begin fails++; $display("FAIL a0_ptr got=%0d exp=3", ptr); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] prev;
    do_reset();
    prev = rf_d[9];
    v = 4'b0001; a = '0; a[0] = 5'd9; d[0] = 32'h99; #1;
    checks++; if (rdy !== 4'b0001) begin fails++; $display("FAIL mid_ready got=%b exp=0001", rdy); end
    tick(); rst = 1'b1; v = '0; #1;
    checks++; if (ena !== 2'b00) begin fails++; $display("FAIL mid_ena got=%b exp=00", ena); end
    tick(); rst = 1'b0; #1;
    checks++; if (rf_d[9] !== prev) begin fails++; $display("FAIL mid_rf got=%h exp=%h", rf_d[9], prev); end
    checks++; if (ptr !== 2'd0 || ena !== 2'b00) begin fails++; $display("FAIL mid_state got=%0d %b exp=0 00", ptr, ena); end
  endtask

  task automatic test_random();
    do_reset();
    last_rdy = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] || last_rdy[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      #1;
      model_eval();
      checks++; if (rdy !== m_rdy) begin fails++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, rdy, m_rdy); end
      checks++; if (ena !== m_ena) begin fails++; $display("FAIL rnd_ena c=%0d got=%b exp=%b", c, ena, m_ena); end
      checks++; if (wa !== m_addr || wd !== m_data) begin fails++; $display("FAIL rnd_wr c=%0d got=%h %h exp=%h %h", c, wa, wd, m_addr, m_data); end
      checks++; if (ptr !== 2'(m_ptr)) begin fails++; $display("FAIL rnd_ptr c=%0d got=%0d exp=%0d", c, ptr, m_ptr); end
      tick();
    end
    v = '0; tick(); tick();
    for (int r = 0; r < 2**AW; r++) begin
      checks++; if (rf_d[r] !== rf_m[r]) begin fails++; $display("FAIL rnd_rf r%0d got=%h exp=%h", r, rf_d[r], rf_m[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 2**AW; r++) begin rf_m[r] = '0; rf_d[r] = '0; end
    test_reset();
    test_two_sources();
    test_four_valid();
    test_conflict();
    test_addr0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
